shift_register_universal: RTL and testbench
===========================================

Name: shift_register_universal

Overview:
Parametrised successor to the team's 8-bit serial-in/parallel-out shift register. It adds the following:
- configurable width
- bidirectional shift
- parallel load
- serial outputs at both ends
- a shift counter with a word-complete strobe

It sits between serial I/O pins and parallel datapath logic. It is used for both deserialising and serialising.

Parameters:
WIDTH, 8, register width in bits; legal range 2..32
CNT_W, $clog2(WIDTH+1), width of shift counter; derived, not to be overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
mode  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load
sin_lsb  input  1  serial input entering bit 0 on shift left
sin_msb  input  1  serial input entering bit WIDTH-1 on shift right
load_data  input  WIDTH  parallel data captured on mode 11
data_out  output  WIDTH  current register contents
sout_msb  output  1  data_out[WIDTH-1], combinational from register
sout_lsb  output  1  data_out[0], combinational from register
shift_count  output  CNT_W  shifts since last load/reset/wrap
word_done  output  1  one-cycle pulse after the WIDTH-th shift

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset asserted: immediately, with no clock needed:
  - data_out = 0
  - shift_count = 0
  - word_done = 0
- Reset deasserted: operation resumes from the first rising clk edge where reset is low. Reset mid-shift discards the partial word and gives no word_done.
- All state updates on rising clk.
- mode 00 (hold): data_out and shift_count unchanged; word_done = 0.
- mode 01 (shift left): data_out <= {data_out[WIDTH-2:0], sin_lsb}.
- mode 10 (shift right): data_out <= {sin_msb, data_out[WIDTH-1:1]}.
- mode 11 (load): data_out <= load_data; shift_count <= 0; word_done <= 0.
- Shift counter, on either shift mode:
  - If shift_count == WIDTH-1: shift_count <= 0 and word_done <= 1 on the same edge. word_done is therefore high during the cycle after the WIDTH-th shift.
  - Otherwise: shift_count <= shift_count+1 and word_done <= 0.
- word_done is registered and never held for more than one cycle unless consecutive WIDTH-shift words complete back-to-back. That is impossible for WIDTH >= 2, so it is always a single-cycle pulse.
- Direction change mid-word: the counter keeps counting. Direction does not reset the count.
- Latency: data_out reflects any operation one clock after the edge on which it was sampled. sout_* follow data_out with zero added latency.
- Mode encodings are mutually exclusive, so there are no simultaneous-event priority rules beyond reset > everything.

Optional Feature:
Macro SHIFT_REG_ROTATE_EN.
- When defined:
  - Extra input port rotate (1 bit).
  - While rotate = 1, shift-left takes data_out[WIDTH-1] into bit 0 instead of sin_lsb.
  - While rotate = 1, shift-right takes data_out[0] into bit WIDTH-1 instead of sin_msb.
  - Counter and word_done behave identically to a normal shift.
- When undefined: no rotate port; shifts always use the sin_* inputs.

Decomposition:
- Package shift_register_pkg holds:
  - mode localparams MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11
  - a mode_t 2-bit typedef
- One natural sub-module: shift_counter. It contains the CNT_W counter, its wrap at WIDTH-1 and the word_done register. Its inputs are shift_en and clear, and it is instantiated once.

Test Plan:
- Reset behaviour, WIDTH=8:
  - Load 8'hA5, then assert reset asynchronously between edges.
  - Required: data_out=8'h00, shift_count=0, word_done=0 before the next edge.
  - Required: they stay 0 after release until a non-hold mode arrives.
- Shift-left deserialise:
  - After reset, mode=01, sin_lsb = 0,1,0,1,0,1,0,1 over 8 edges.
  - Required: data_out=8'b01010101.
  - Required: shift_count counts 1..7, then 0.
  - Required: word_done=1 for exactly the cycle after the 8th edge.
- Parallel load and serialise right:
  - Load 8'hC3, then mode=10 with sin_msb=0 for 8 edges.
  - Required: sout_lsb sequence 1,1,0,0,0,0,1,1.
  - Required: data_out=8'h00 at the end.
  - Required: word_done pulse after the 8th shift.
- Hold and reload:
  - After 3 shifts (shift_count=3), mode=00 for 4 cycles.
  - Required: data_out and shift_count unchanged.
  - Then load 8'h3C. Required: shift_count=0, data_out=8'h3C, no word_done.
- Reset mid-word:
  - Shift 5 bits, assert reset for one cycle.
  - Required: all outputs 0.
  - Required: the next 8 shifts produce word_done only after the 8th, not the 3rd.
- Parametrisation and rotate, WIDTH=4 with SHIFT_REG_ROTATE_EN:
  - Load 4'b1000, rotate=1, mode=01 for 4 edges.
  - Required: data_out sequence 0001, 0010, 0100, 1000.
  - Required: word_done pulse after the 4th edge.

Source files
------------

// File: rtl/shift_register_pkg.sv
// shift_register_pkg: mode encoding shared by the universal shift register and its bench
// Contents: mode_t (2-bit operation select) and the four mode localparams.
package shift_register_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHL  = 2'b01;
  localparam mode_t MODE_SHR  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;
endpackage

// File: rtl/shift_counter.sv
// shift_counter: counts shifts modulo WIDTH and pulses done for the cycle after each full word
// Ports: clk, reset (async, active-high), shift_en (a shift happens this edge),
//        clear (load: restart the word), count (shifts so far), done (registered word-complete pulse).
module shift_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             done
);
  logic wrap;
  assign wrap = shift_en && count == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      count <= clear || wrap ? '0 : shift_en ? count + CNT_W'(1) : count;
      done  <= wrap && !clear;
    end
  end
endmodule

// File: rtl/shift_register_universal.sv
// shift_register_universal: bidirectional shift register with parallel load, serial taps and word counter
// Ports: clk, reset (async, active-high), mode (00 hold/01 left/10 right/11 load), sin_lsb, sin_msb,
//        load_data, data_out, sout_msb, sout_lsb, shift_count, word_done,
//        rotate (only when SHIFT_REG_ROTATE_EN is defined: shifts recirculate the outgoing bit).
module shift_register_universal
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  mode_t            mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data_out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] shift_count,
  output logic             word_done
);
  logic [WIDTH-1:0] data_d;
  logic shl_in, shr_in;
`ifdef SHIFT_REG_ROTATE_EN
  assign shl_in = rotate ? data_out[WIDTH-1] : sin_lsb;
  assign shr_in = rotate ? data_out[0] : sin_msb;
`else
  assign shl_in = sin_lsb;
  assign shr_in = sin_msb;
`endif
  always_comb begin
    data_d = mode == MODE_HOLD ? data_out :
             mode == MODE_LOAD ? load_data :
             mode == MODE_SHL  ? {data_out[WIDTH-2:0], shl_in} :
                                 {shr_in, data_out[WIDTH-1:1]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_out <= '0;
    else data_out <= data_d;
  end
  assign sout_msb = data_out[WIDTH-1];
  assign sout_lsb = data_out[0];
  shift_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .shift_en (mode == MODE_SHL || mode == MODE_SHR),
    .clear    (mode == MODE_LOAD),
    .count    (shift_count),
    .done     (word_done)
  );
endmodule

// File: tb/tb_shift_register_universal.sv
// tb_shift_register_universal: scoreboard bench for the universal shift register (WIDTH=8, plus WIDTH=4 rotate when SHIFT_REG_ROTATE_EN)
module tb_shift_register_universal;
  typedef struct packed {logic [7:0] d; logic [3:0] c; logic w;} exp_t;
  logic clk = 0, reset = 1;
  logic [1:0] mode = 2'b00;
  logic sin_lsb = 0, sin_msb = 0;
  logic [7:0] load_data = '0;
  logic [7:0] data_out;
  logic sout_msb, sout_lsb, word_done;
  logic [3:0] shift_count;
  exp_t q[$];
  exp_t e;
  logic [7:0] md;
  logic [3:0] mc;
  logic mw;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  shift_register_universal #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
`ifdef SHIFT_REG_ROTATE_EN
    .rotate(1'b0),
`endif
    .load_data(load_data), .data_out(data_out), .sout_msb(sout_msb), .sout_lsb(sout_lsb),
    .shift_count(shift_count), .word_done(word_done)
  );
`ifdef SHIFT_REG_ROTATE_EN
  logic [1:0] mode4 = 2'b00;
  logic rot = 0;
  logic [3:0] ld4 = '0, data4;
  logic [2:0] cnt4;
  logic done4, smsb4, slsb4;
  logic [4:0] q4[$];
  logic [4:0] e4;
  shift_register_universal #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .mode(mode4), .sin_lsb(1'b0), .sin_msb(1'b0), .rotate(rot),
    .load_data(ld4), .data_out(data4), .sout_msb(smsb4), .sout_lsb(slsb4),
    .shift_count(cnt4), .word_done(done4)
  );
`endif
  task automatic model_reset();
    md = '0; mc = '0; mw = 0; q.delete();
  endtask
  task automatic drive(input logic [1:0] m, input logic sl, input logic sm, input logic [7:0] ld);
    mode = m; sin_lsb = sl; sin_msb = sm; load_data = ld;
    if (m == 2'b11) begin md = ld; mc = 0; mw = 0; end
    else if (m == 2'b00) mw = 0;
    else begin
      md = m == 2'b01 ? {md[6:0], sl} : {sm, md[7:1]};
      mw = mc == 4'd7;
      mc = mw ? 4'd0 : mc + 4'd1;
    end
    q.push_back({md, mc, mw});
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    reset = 1; model_reset();
    #1; checks++;
    if ({data_out, shift_count, word_done} !== 13'd0) begin
      errors++; $display("FAIL reset_init: got d=%h c=%0d w=%b want 0", data_out, shift_count, word_done);
    end
    @(posedge clk); #1; reset = 0;
    drive(2'b11, 0, 0, 8'hA5);
    e = q.pop_front(); checks++;
    if ({data_out, shift_count, word_done} !== e) begin
      errors++; $display("FAIL reset_load: got d=%h c=%0d w=%b want d=%h c=%0d w=%b", data_out, shift_count, word_done, e.d, e.c, e.w);
    end
    #2 reset = 1; model_reset();
    #1; checks++;
    if ({data_out, shift_count, word_done} !== 13'd0) begin
      errors++; $display("FAIL reset_async: got d=%h c=%0d w=%b want 0", data_out, shift_count, word_done);
    end
    @(posedge clk); #1; reset = 0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1, 1, 8'hFF);
      e = q.pop_front(); checks++;
      if ({data_out, shift_count, word_done} !== e || data_out !== 8'h00) begin
        errors++; $display("FAIL reset_hold[%0d]: got d=%h c=%0d w=%b want 0", i, data_out, shift_count, word_done);
      end
    end
  endtask
  task automatic test_shift_left();
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, i[0], 0, 8'h00);
      e = q.pop_front(); checks++;
      if ({data_out, shift_count, word_done} !== e || shift_count !== 4'((i + 1) % 8) || word_done !== (i == 7)) begin
        errors++; $display("FAIL shl[%0d]: got d=%h c=%0d w=%b want d=%h c=%0d w=%b", i, data_out, shift_count, word_done, e.d, e.c, e.w);
      end
    end
    checks++;
    if (data_out !== 8'b01010101) begin
      errors++; $display("FAIL shl_word: got %h want 55", data_out);
    end
    drive(2'b00, 0, 0, 8'h00);
    e = q.pop_front(); checks++;
    if ({data_out, shift_count, word_done} !== e || word_done !== 1'b0) begin
      errors++; $display("FAIL shl_pulse_end: got w=%b want 0", word_done);
    end
  endtask
  task automatic test_serialise_right();
    logic [7:0] seq;
    seq = 8'hC3;
    drive(2'b11, 0, 0, 8'hC3);
    e = q.pop_front(); checks++;
    if ({data_out, shift_count, word_done} !== e) begin
      errors++; $display("FAIL shr_load: got d=%h want %h", data_out, e.d);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sout_lsb !== seq[i] || sout_msb !== md[7]) begin
        errors++; $display("FAIL shr_sout[%0d]: got lsb=%b msb=%b want lsb=%b msb=%b", i, sout_lsb, sout_msb, seq[i], md[7]);
      end
      drive(2'b10, 1, 0, 8'h00);
      e = q.pop_front(); checks++;
      if ({data_out, shift_count, word_done} !== e) begin
        errors++; $display("FAIL shr[%0d]: got d=%h c=%0d w=%b want d=%h c=%0d w=%b", i, data_out, shift_count, word_done, e.d, e.c, e.w);
      end
    end
    checks++;
    if (data_out !== 8'h00 || word_done !== 1'b1) begin
      errors++; $display("FAIL shr_end: got d=%h w=%b want 00 1", data_out, word_done);
    end
  endtask
  task automatic test_hold_reload();
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1, 0, 8'h00);
      void'(q.pop_front());
    end
    checks++;
    if (data_out !== 8'h07 || shift_count !== 4'd3) begin
      errors++; $display("FAIL hold_pre: got d=%h c=%0d want 07 3", data_out, shift_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 0, 1, 8'hFF);
      e = q.pop_front(); checks++;
      if ({data_out, shift_count, word_done} !== e || data_out !== 8'h07 || shift_count !== 4'd3) begin
        errors++; $display("FAIL hold[%0d]: got d=%h c=%0d w=%b want 07 3 0", i, data_out, shift_count, word_done);
      end
    end
    drive(2'b11, 0, 0, 8'h3C);
    e = q.pop_front(); checks++;
    if ({data_out, shift_count, word_done} !== e || {data_out, shift_count, word_done} !== {8'h3C, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reload: got d=%h c=%0d w=%b want 3c 0 0", data_out, shift_count, word_done);
    end
  endtask
  task automatic test_reset_mid_word();
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 1, 0, 8'h00);
      void'(q.pop_front());
    end
    reset = 1; model_reset(); mode = 2'b00;
    #1; checks++;
    if ({data_out, shift_count, word_done} !== 13'd0) begin
      errors++; $display("FAIL mid_reset: got d=%h c=%0d w=%b want 0", data_out, shift_count, word_done);
    end
    @(posedge clk); #1; reset = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 1, 0, 8'h00);
      e = q.pop_front(); checks++;
      if ({data_out, shift_count, word_done} !== e || word_done !== (i == 7)) begin
        errors++; $display("FAIL mid_shift[%0d]: got d=%h c=%0d w=%b want d=%h c=%0d w=%b", i, data_out, shift_count, word_done, e.d, e.c, e.w);
      end
    end
  endtask
`ifdef SHIFT_REG_ROTATE_EN
  task automatic test_rotate();
    logic [3:0] r;
    mode = 2'b00; ld4 = 4'b1000; mode4 = 2'b11;
    @(posedge clk); #1;
    r = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      q4.push_back({r, i == 3});
      r = {r[2:0], r[3]};
    end
    rot = 1; mode4 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e4 = q4.pop_front(); checks++;
      if ({data4, done4} !== e4) begin
        errors++; $display("FAIL rotate[%0d]: got d=%b w=%b want d=%b w=%b", i, data4, done4, e4[4:1], e4[0]);
      end
    end
    mode4 = 2'b00; rot = 0;
    @(posedge clk); #1; checks++;
    if (done4 !== 1'b0 || data4 !== 4'b1000) begin
      errors++; $display("FAIL rotate_end: got d=%b w=%b want 1000 0", data4, done4);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_shift_left();
    test_serialise_right();
    test_hold_reload();
    test_reset_mid_word();
`ifdef SHIFT_REG_ROTATE_EN
    test_rotate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
